// File: rtl/writeback_ctrl.sv
// -----------------------------------------------------------------------------
// writeback_ctrl
//
// Write-back sequencer for the single-cycle ALU / synchronous RAM datapath.
// It accepts one decoded instruction at a time. For each accepted instruction
// it drives the ALU/RAM output mux select and strobes the RAM read for loads.
// It raises the register-file write enable and address once the selected data
// is valid.
//
// Parameters
//   RADDR_W     register-file address width
//   TIMEOUT     counter value in MEM_WAIT at which a load is abandoned (1..255)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   op_valid     decoder presents an instruction
//   op_ready     controller can accept (transfer on op_valid && op_ready)
//   op_is_load   instruction result comes from RAM
//   op_wen       instruction writes a register
//   op_rd        destination register
//   ram_re       one-cycle RAM read strobe
//   ram_rvalid   RAM read data valid this cycle (only looked at in MEM_WAIT)
//   sel          output mux select: 0 = ALU result, 1 = RAM read data
//   rf_we        register-file write enable
//   rf_waddr     register-file write address (holds between writes)
//   busy         controller is not idle
//   err_timeout  sticky load-timeout flag
//
// Optional feature
//   WB_TIMEOUT_EN  when defined, a load that waits too long in MEM_WAIT is
//                  abandoned and err_timeout is set. When undefined, MEM_WAIT
//                  waits indefinitely, no counter exists, and err_timeout is 0.
// -----------------------------------------------------------------------------
module writeback_ctrl #(
    parameter int RADDR_W = 5,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic               op_is_load,
    input  logic               op_wen,
    input  logic [RADDR_W-1:0] op_rd,
    output logic               ram_re,
    input  logic               ram_rvalid,
    output logic               sel,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic               busy,
    output logic               err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ALU_WB   = 2'd1,
        ST_MEM_REQ  = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [RADDR_W-1:0] waddr_q, waddr_d;
    logic               xfer_s;
    logic               accept_state_s;

`ifdef WB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    // IDLE and ALU_WB both accept a new op. ALU_WB accepting is what gives
    // back-to-back ALU ops one write per cycle.
    assign accept_state_s = (state_q == ST_IDLE) || (state_q == ST_ALU_WB);
    assign op_ready       = rst_n && accept_state_s;
    assign xfer_s         = op_valid && op_ready;

    assign sel      = (state_q == ST_MEM_REQ) || (state_q == ST_MEM_WAIT);
    assign ram_re   = rst_n && (state_q == ST_MEM_REQ);
    // The load write is combinational from ram_rvalid so that the data is
    // captured in the same cycle the RAM presents it. Gating with rst_n keeps
    // a load that is being reset from writing.
    assign rf_we    = rst_n && ((state_q == ST_ALU_WB) ||
                                ((state_q == ST_MEM_WAIT) && ram_rvalid));
    assign rf_waddr = waddr_q;
    assign busy     = (state_q != ST_IDLE);

`ifdef WB_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    // Next-state, write-address and timeout bookkeeping.
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
`ifdef WB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE, ST_ALU_WB: begin
                state_d = ST_IDLE;
                // Ops without a register write (including stores) are
                // consumed here without touching the write address.
                if (xfer_s && op_wen) begin
                    waddr_d = op_rd;
                    if (op_is_load) begin
                        state_d = ST_MEM_REQ;
                    end else begin
                        state_d = ST_ALU_WB;
                    end
                end else begin
                    waddr_d = waddr_q;
                end
            end
            ST_MEM_REQ: begin
                state_d = ST_MEM_WAIT;
`ifdef WB_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end
            ST_MEM_WAIT: begin
                if (ram_rvalid) begin
                    // Data arriving on the timeout cycle still wins.
                    state_d = ST_IDLE;
                end else begin
`ifdef WB_TIMEOUT_EN
                    if (cnt_q == TIMEOUT_C) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
`else
                    state_d = ST_MEM_WAIT;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath-control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            waddr_q <= {RADDR_W{1'b0}};
`ifdef WB_TIMEOUT_EN
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
`ifdef WB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: doc/writeback_ctrl.md
# writeback_ctrl

Write-back sequencer for the single-cycle-ALU / synchronous-RAM datapath. It accepts one decoded instruction at a time and drives the `sel` input of the ALU/RAM output mux (0 = ALU result, 1 = RAM read data). It strobes the RAM read for loads and generates the register-file write enable and address once the selected data is valid. It sits between the instruction decoder and the register file write port.

## Interface
Parameters:
- `RADDR_W`, default 5: register-file address width.
- `TIMEOUT`, default 15: maximum cycles spent in MEM_WAIT before abort (range 1..255).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `op_valid`, input, 1: decoder presents an instruction.
- `op_ready`, output, 1: controller can accept; transfer occurs when `op_valid && op_ready` at a rising edge.
- `op_is_load`, input, 1: instruction is a load (result comes from RAM).
- `op_wen`, input, 1: instruction writes a register.
- `op_rd`, input, RADDR_W: destination register.
- `ram_re`, output, 1: RAM read strobe, one cycle.
- `ram_rvalid`, input, 1: RAM read data valid on `ram_out` this cycle.
- `sel`, output, 1: output mux select.
- `rf_we`, output, 1: register-file write enable.
- `rf_waddr`, output, RADDR_W: register-file write address.
- `busy`, output, 1: state is not IDLE.
- `err_timeout`, output, 1: sticky load-timeout flag.

## Operation
- States: IDLE, ALU_WB, MEM_REQ, MEM_WAIT.
- Accepted `op_rd` is latched into `rf_waddr`; `rf_waddr` holds its value between writes.
- **IDLE** (`op_ready`=1). On transfer:
  - `!op_wen` → stay in IDLE; the op is consumed with no write.
  - `op_wen && !op_is_load` → ALU_WB.
  - `op_wen && op_is_load` → MEM_REQ.
- **ALU_WB**:
  - `sel`=0 and `rf_we`=1 for exactly one cycle.
  - `op_ready`=1, so a new op may transfer in the same cycle and is dispatched exactly as from IDLE. Otherwise the next state is IDLE.
  - The datapath holds `alu_out` stable during this cycle.
- **MEM_REQ**:
  - `ram_re`=1, `sel`=1, `op_ready`=0.
  - Clears the wait counter and always moves to MEM_WAIT.
- **MEM_WAIT**:
  - `sel`=1, `op_ready`=0.
  - When `ram_rvalid`=1, `rf_we`=1 in that same cycle (combinational from `ram_rvalid`), then the next state is IDLE.
  - When `ram_rvalid`=0, the counter increments.
- `ram_rvalid` is ignored in every state except MEM_WAIT.
- Opcodes with both `op_is_load`=1 and `op_wen`=0 (stores) take the no-write path; stores are not handled here.
- `sel` is 1 only in MEM_REQ and MEM_WAIT; otherwise it is 0.
- `busy` = (state != IDLE).

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - state IDLE and counter 0;
  - `sel`=0, `rf_we`=0, `ram_re`=0, `rf_waddr`=0, `err_timeout`=0;
  - `op_ready`=0 while `rst_n` is low.
- Reset mid-load abandons the load with no write; a late `ram_rvalid` is ignored.
- ALU op accepted at edge N: `rf_we` high during cycle N+1. Back-to-back ALU ops sustain one write per cycle.
- Load accepted at edge N: `ram_re` high in cycle N+1. The earliest `rf_we` is cycle N+2, if `ram_rvalid` is high in N+2. Throughput is at most one load per 3 cycles.
- Counter width is 8 bits. It is saturating and never wraps.

## Configuration
- `WB_TIMEOUT_EN` defined:
  - In MEM_WAIT, if the counter equals TIMEOUT and `ram_rvalid`=0, the controller sets `err_timeout`, asserts no `rf_we`, and returns to IDLE.
  - `ram_rvalid` arriving in the same cycle the counter reaches TIMEOUT wins: the write happens and no error is raised.
  - `err_timeout` clears only on reset.
- `WB_TIMEOUT_EN` undefined:
  - MEM_WAIT waits indefinitely.
  - No counter logic is present, and `err_timeout` is tied to 0.

## Test plan
- ALU op (`op_wen`=1, `op_is_load`=0, `op_rd`=5'd3) accepted at edge N → `sel`=0, `rf_we`=1, `rf_waddr`=3 in cycle N+1 only.
- Three back-to-back ALU ops with `rd`=1,2,3 → `rf_we` high for 3 consecutive cycles with `rf_waddr` 1,2,3 and `op_ready` never low.
- Load with `rd`=7 and `ram_rvalid` 2 cycles after `ram_re` → `ram_re` one cycle; `sel`=1 for 3 cycles; `rf_we`=1, `rf_waddr`=7 in the `ram_rvalid` cycle; `op_ready` low throughout.
- Op with `op_wen`=0 → no `rf_we` and no `ram_re`; `op_ready` stays 1 and `busy` stays 0.
- With `WB_TIMEOUT_EN` and TIMEOUT=4, a load with no `ram_rvalid` → IDLE after 4 wait cycles with `err_timeout`=1 and no `rf_we`. A subsequent ALU op still writes normally, and `err_timeout` stays 1 until `rst_n`=0.
- `rst_n`=0 asserted during MEM_WAIT, then `ram_rvalid` pulsed after release → all outputs 0 at the reset edge; no `rf_we` occurs afterwards.
